abs_pos_calculator: RTL and testbench
=====================================

ABS_POS_CALCULATOR -- requirements
Module: abs_pos_calculator

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all logic on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide: start  input  1  one-cycle request, sampled only when ready=1.
REQ-004 SHALL provide: hw_counter  input  32  signed encoder count.
REQ-005 SHALL provide: set_position_part1  input  32  low word of signed 64-bit set position.
REQ-006 SHALL provide: set_position_part2  input  32  high word of signed 64-bit set position.
REQ-007 SHALL provide: counts_per_m  input  32  unsigned encoder counts per metre.
REQ-008 SHALL provide: ready  output  1  high only in IDLE.
REQ-009 SHALL provide: done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide: abs_pos  output  64  signed absolute position in nanometres.
REQ-011 SHALL provide: div_by_zero  output  1  error flag for the last result, valid with done.

Function
REQ-012 SHALL compute abs_pos = {part2,part1} + trunc0(hw_counter * SCALE / counts_per_m), with SCALE = 1_000_000_000 and trunc0 meaning truncation toward zero.
REQ-013 SHALL run states IDLE -> MULT -> DIV -> ADD -> DONE -> IDLE; no other transitions.
REQ-014 SHALL, in IDLE with start=1, capture all four operand inputs on that edge and enter MULT.
REQ-015 SHALL, in MULT, register |hw_counter| * SCALE as an unsigned 64-bit product, then enter DIV.
REQ-016 SHALL, in DIV, perform exactly 64 restoring-division iterations, one per cycle, then enter ADD.
REQ-017 SHALL, in ADD, apply sign(hw_counter) to the quotient, add the set position, register abs_pos, then enter DONE.
REQ-018 SHALL perform the 64-bit addition modulo 2^64, with no saturation.
REQ-019 SHALL hold done=1 and ready=0 for exactly the DONE cycle; done rises 66 edges after the start-sampling edge.
REQ-020 SHALL keep a fixed 66-cycle latency regardless of operand values.
REQ-021 SHALL hold abs_pos and div_by_zero stable from ADD until the next ADD.
REQ-022 SHALL ignore start whenever ready=0, including the DONE cycle; no queuing.
REQ-023 SHALL, when captured counts_per_m=0, force the quotient to 0 (abs_pos = set position) and set div_by_zero=1 with done.
REQ-024 SHALL clear div_by_zero on the ADD of any computation whose divisor is nonzero.
REQ-025 SHALL ignore input changes after capture.
REQ-026 SHALL return the correct magnitude 2^31*SCALE for hw_counter=-2^31, with no overflow of the 64-bit product.

Reset
REQ-027 SHALL, on rst=0 at a clock edge, enter IDLE and set ready=1, done=0, abs_pos=0, div_by_zero=0, and clear all internal registers.
REQ-028 SHALL abort any in-flight computation on reset, with no done pulse for it.
REQ-029 SHALL accept start on the first edge after rst returns high.

Structure
REQ-030 SHALL place the state encoding, SCALE and DIV_ITER=64 in shared package abs_pos_pkg.
REQ-031 SHALL implement the iterative divider as sub-module abs_pos_divider, with load/busy/done handshake, 64-bit dividend, 32-bit divisor and 64-bit quotient.

Verification
REQ-032 SHALL cover: hw=1000, cpm=1_000_000, set=0 -> abs_pos=1_000_000, done 66 cycles after start, div_by_zero=0.
REQ-033 SHALL cover: hw=-3, cpm=7, set=0 -> abs_pos=-428_571_428 (truncation toward zero).
REQ-034 SHALL cover: part2=1, part1=0, hw=0, cpm=1 -> abs_pos=4_294_967_296.
REQ-035 SHALL cover: cpm=0, set=5, hw=123 -> abs_pos=5, div_by_zero=1; a following valid request -> div_by_zero=0.
REQ-036 SHALL cover: start re-pulsed at cycle 10 of a computation -> single done, result of the first operands only.
REQ-037 SHALL cover: rst=0 at cycle 30 of a computation -> no done, abs_pos=0, ready=1 next cycle; then hw=-2^31, cpm=1, set=0 -> abs_pos=-2_147_483_648_000_000_000.

Source files
------------

// File: rtl/abs_pos_pkg.sv
// Shared definitions for the absolute-position calculator.
// Contents: controller state encoding, the nanometre scale factor, the
// divider iteration count and small arithmetic helpers used by the
// controller and the iterative divider.
package abs_pos_pkg;

  // Controller states; the only legal path is IDLE->MULT->DIV->ADD->DONE->IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_ADD  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Encoder counts are scaled to nanometres (1 m = 1e9 nm).
  localparam logic [63:0] SCALE = 64'd1_000_000_000;

  // One quotient bit per cycle for a 64-bit dividend.
  localparam int unsigned DIV_ITER = 64;
  localparam int unsigned CNT_W    = 7;

  // Partial remainder and shifting dividend/quotient of the restoring divider.
  typedef struct packed {
    logic [31:0] rem;
    logic [63:0] quo;
  } div_step_t;

  // One restoring-division step. The shifted remainder needs 33 bits, but the
  // kept remainder is always below the 32-bit divisor so 32 bits suffice.
  function automatic div_step_t div_step(input logic [31:0] rem,
                                         input logic [63:0] quo,
                                         input logic [31:0] divisor);
    logic [32:0] shifted;
    logic [32:0] trial;
    div_step_t   res;
    shifted = {rem, quo[63]};
    trial   = shifted - {1'b0, divisor};
    res.quo = {quo[62:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      res.rem    = trial[31:0];
      res.quo[0] = 1'b1;
    end else begin
      res.rem    = shifted[31:0];
    end
    return res;
  endfunction

  // Magnitude of a signed 32-bit value as unsigned; -2^31 maps to 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] val);
    logic [31:0] res;
    if (val[31]) begin
      res = ~val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Two's-complement negation of a 64-bit value when neg is set.
  function automatic logic [63:0] apply_sign64(input logic [63:0] mag, input logic neg);
    logic [63:0] res;
    if (neg) begin
      res = ~mag + 64'd1;
    end else begin
      res = mag;
    end
    return res;
  endfunction

endpackage

// File: rtl/abs_pos_divider.sv
// Iterative unsigned restoring divider: 64-bit dividend / 32-bit divisor.
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      synchronous active-low reset
//   load_i      start a division (accepted only while not busy); the first
//               quotient bit is produced on the load edge itself
//   dividend_i  64-bit unsigned dividend, sampled with load_i
//   divisor_i   32-bit unsigned divisor, sampled with load_i
//   busy_o      high while iterations 2..DIV_ITER are in progress
//   done_o      high during the cycle in which the final iteration is
//               applied; quotient_o is final from the following cycle
//   quotient_o  64-bit quotient (all ones for a zero divisor)
module abs_pos_divider
  import abs_pos_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [63:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] quotient_o
);

  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(DIV_ITER - 2);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DIV_ITER - 1);

  logic [31:0]      rem_q, rem_d;
  logic [63:0]      quo_q, quo_d;
  logic [31:0]      divisor_q, divisor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_s;
  div_step_t        step_s;

  assign load_s = load_i & ~busy_q;

  // On load the step works directly on the fresh operands so no cycle is lost.
  assign step_s = load_s ? div_step(32'd0, dividend_i, divisor_i)
                         : div_step(rem_q, quo_q, divisor_q);

  // Next-state logic: load, iterate, or hold.
  always_comb begin
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (load_s) begin
      rem_d     = step_s.rem;
      quo_d     = step_s.quo;
      divisor_d = divisor_i;
      cnt_d     = CNT_W'(1);
      busy_d    = 1'b1;
    end else if (busy_q) begin
      rem_d  = step_s.rem;
      quo_d  = step_s.quo;
      cnt_d  = cnt_q + CNT_W'(1);
      // Flag raised one edge early so the controller can leave DIV exactly
      // when the last quotient bit lands.
      done_d = (cnt_q == CNT_PRE_LAST);
      busy_d = (cnt_q != CNT_LAST);
    end else begin
      done_d = 1'b0;
    end
  end

  // Divider state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q     <= 32'd0;
      quo_q     <= 64'd0;
      divisor_q <= 32'd0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/abs_pos_calculator.sv
// Absolute position calculator: abs_pos = set_position + trunc0(hw * 1e9 / cpm)
// with a fixed 66-cycle latency from the start-sampling edge to done.
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous active-low reset
//   start               request, sampled only while ready=1
//   hw_counter          signed 32-bit encoder count
//   set_position_part1  low word of signed 64-bit set position
//   set_position_part2  high word of signed 64-bit set position
//   counts_per_m        unsigned encoder counts per metre
//   ready               high only in IDLE
//   done                one-cycle completion pulse
//   abs_pos             signed 64-bit position in nanometres
//   div_by_zero         set when the last request had counts_per_m=0
module abs_pos_calculator
  import abs_pos_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] hw_counter,
  input  logic [31:0] set_position_part1,
  input  logic [31:0] set_position_part2,
  input  logic [31:0] counts_per_m,
  output logic        ready,
  output logic        done,
  output logic [63:0] abs_pos,
  output logic        div_by_zero
);

  state_e      state_q, state_d;
  logic [31:0] hw_q, hw_d;
  logic [31:0] cpm_q, cpm_d;
  logic [63:0] set_q, set_d;
  logic [63:0] product_q, product_d;
  logic [63:0] abs_pos_q, abs_pos_d;
  logic        dbz_q, dbz_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic        div_load_s;
  logic        div_busy_s;
  logic        div_done_s;
  logic [63:0] div_quo_s;
  logic [63:0] product_s;
  logic [63:0] quo_signed_s;
  logic [63:0] sum_s;

  // |hw| <= 2^31, so |hw| * 1e9 < 2^61 and the unsigned product cannot overflow.
  assign product_s = {32'd0, abs32(hw_q)} * SCALE;

  // Truncation toward zero: divide magnitudes, then restore the sign.
  assign quo_signed_s = (cpm_q == 32'd0) ? 64'd0 : apply_sign64(div_quo_s, hw_q[31]);

  // Plain modulo-2^64 addition.
  assign sum_s = set_q + quo_signed_s;

  abs_pos_divider u_divider (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (div_load_s),
    .dividend_i (product_q),
    .divisor_i  (cpm_q),
    .busy_o     (div_busy_s),
    .done_o     (div_done_s),
    .quotient_o (div_quo_s)
  );

  // Next-state and datapath update for the controller FSM.
  always_comb begin
    state_d    = state_q;
    hw_d       = hw_q;
    cpm_d      = cpm_q;
    set_d      = set_q;
    product_d  = product_q;
    abs_pos_d  = abs_pos_q;
    dbz_d      = dbz_q;
    div_load_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hw_d    = hw_counter;
          cpm_d   = counts_per_m;
          set_d   = {set_position_part2, set_position_part1};
          state_d = ST_MULT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MULT: begin
        product_d = product_s;
        state_d   = ST_DIV;
      end
      ST_DIV: begin
        // Kick the divider once, in the first DIV cycle.
        div_load_s = ~div_busy_s & ~div_done_s;
        if (div_done_s) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_ADD: begin
        abs_pos_d = sum_s;
        dbz_d     = (cpm_q == 32'd0);
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // Controller registers with synchronous reset; reset aborts any request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      hw_q      <= 32'd0;
      cpm_q     <= 32'd0;
      set_q     <= 64'd0;
      product_q <= 64'd0;
      abs_pos_q <= 64'd0;
      dbz_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hw_q      <= hw_d;
      cpm_q     <= cpm_d;
      set_q     <= set_d;
      product_q <= product_d;
      abs_pos_q <= abs_pos_d;
      dbz_q     <= dbz_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign ready       = ready_q;
  assign done        = done_q;
  assign abs_pos     = abs_pos_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_abs_pos_calculator.sv
// Directed self-checking bench for abs_pos_calculator.
module tb_abs_pos_calculator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] hw_counter;
  logic [31:0] set_position_part1;
  logic [31:0] set_position_part2;
  logic [31:0] counts_per_m;
  logic        ready;
  logic        done;
  logic [63:0] abs_pos;
  logic        div_by_zero;

  int checks;
  int failures;
  int lat;
  int ndone;

  abs_pos_calculator dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .hw_counter         (hw_counter),
    .set_position_part1 (set_position_part1),
    .set_position_part2 (set_position_part2),
    .counts_per_m       (counts_per_m),
    .ready              (ready),
    .done               (done),
    .abs_pos            (abs_pos),
    .div_by_zero        (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  // Called at a negedge; the next posedge samples start. Returns at the
  // negedge after that edge with the inputs scrambled to prove they were captured.
  task automatic start_req(input logic [31:0] hw, input logic [31:0] cpm, input logic [63:0] setp);
    start              = 1'b1;
    hw_counter         = hw;
    counts_per_m       = cpm;
    set_position_part1 = setp[31:0];
    set_position_part2 = setp[63:32];
    @(negedge clk);
    start              = 1'b0;
    hw_counter         = 32'hDEAD_BEEF;
    counts_per_m       = 32'h0000_0003;
    set_position_part1 = 32'h1234_5678;
    set_position_part2 = 32'h0BAD_F00D;
  endtask

  // Counts edges after the start-sampling edge until done, with a bound.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] hw, input logic [31:0] cpm,
                          input logic [63:0] setp, input logic [63:0] exp_pos, input logic exp_dbz);
    int n;
    start_req(hw, cpm, setp);
    chk({tag, "_busy_ready"}, 64'(ready), 64'd0);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd66);
    chk({tag, "_abs_pos"}, abs_pos, exp_pos);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    @(negedge clk);
    chk({tag, "_done_width"}, 64'(done), 64'd0);
    chk({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    checks             = 0;
    failures           = 0;
    rst                = 1'b0;
    start              = 1'b0;
    hw_counter         = 32'd0;
    set_position_part1 = 32'd0;
    set_position_part2 = 32'd0;
    counts_per_m       = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_abs_pos", abs_pos, 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);

    // Start on the very first edge after reset release.
    rst = 1'b1;
    run_case("basic", 32'd1000, 32'd1_000_000, 64'd0, 64'd1_000_000, 1'b0);
    run_case("neg_trunc", -32'sd3, 32'd7, 64'd0, -64'sd428_571_428, 1'b0);
    run_case("set_hi", 32'd0, 32'd1, 64'h0000_0001_0000_0000, 64'd4_294_967_296, 1'b0);
    run_case("div0", 32'd123, 32'd0, 64'd5, 64'd5, 1'b1);
    run_case("after_div0", 32'd7, 32'd2, 64'd0, 64'd3_500_000_000, 1'b0);
    run_case("wrap", 32'd1, 32'd1_000_000_000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);

    // Start re-pulsed mid-computation must be ignored.
    start_req(32'd2, 32'd1, 64'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 10) begin
        start        = 1'b1;
        hw_counter   = 32'd5;
        counts_per_m = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("repulse_latency", 64'(lat), 64'd66);
    chk("repulse_abs_pos", abs_pos, 64'd2_000_000_000);
    // Start during the DONE cycle must also be ignored.
    start        = 1'b1;
    hw_counter   = 32'd9;
    counts_per_m = 32'd1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ready", 64'(ready), 64'd1);
    ndone = 0;
    repeat (80) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("no_extra_done", 64'(ndone), 64'd0);
    chk("abs_pos_held", abs_pos, 64'd2_000_000_000);
    chk("idle_ready", 64'(ready), 64'd1);

    // Reset in the middle of a computation aborts it.
    start_req(32'd100, 32'd1, 64'd0);
    repeat (29) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_abs_pos", abs_pos, 64'd0);
    rst = 1'b1;
    // An aborted run leaking a done would shorten this latency.
    run_case("min_hw", 32'h8000_0000, 32'd1, 64'd0, -64'sd2_147_483_648_000_000_000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
